// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types and helpers for the pipelined FP multiplier.
//   fp_class_e  - operand class after unpacking (subnormals are treated as zero)
//   fp_flags_t  - {invalid, overflow, underflow, inexact}, MSB first
//   canon_nan() - canonical quiet NaN bit pattern for a given format
//   classify()  - operand class from exponent/mantissa summary bits
// The flag type is only consumed when FP_MUL_FLAGS_EN is defined.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        ClsZero,
        ClsNorm,
        ClsInf,
        ClsQnan,
        ClsSnan
    } fp_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Widest packed format the helpers support; callers slice down to W bits.
    localparam int unsigned MaxWidth = 64;

    // Sign 0, exponent all ones, mantissa MSB set, remaining mantissa bits zero.
    function automatic logic [MaxWidth-1:0] canon_nan(input int unsigned exp_w,
                                                      input int unsigned man_w);
        logic [MaxWidth-1:0] v;
        v = ((MaxWidth'(1) << exp_w) - MaxWidth'(1)) << man_w;
        v = v | (MaxWidth'(1) << (man_w - 1));
        return v;
    endfunction

    // Exponent zero flushes to zero regardless of mantissa (no subnormal support).
    function automatic fp_class_e classify(input logic exp_ones, input logic exp_zero,
                                           input logic man_zero, input logic man_msb);
        fp_class_e c;
        if (exp_zero) begin
            c = ClsZero;
        end else if (exp_ones) begin
            if (man_zero) begin
                c = ClsInf;
            end else if (man_msb) begin
                c = ClsQnan;
            end else begin
                c = ClsSnan;
            end
        end else begin
            c = ClsNorm;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_mul_if.sv
// fp_mul_if: operand/result handshake bundle for fp_mul_pipe.
//   in_valid/in_ready/in_a/in_b           - operand pair transfer
//   out_valid/out_ready/out_result         - product transfer
//   out_flags {invalid,overflow,underflow,inexact} - only with FP_MUL_FLAGS_EN
// master: issuing side; slave: the multiplier.
interface fp_mul_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) ();
    import fp_mul_pkg::*;

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
`ifdef FP_MUL_FLAGS_EN
    fp_flags_t    out_flags;
`endif

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
`ifdef FP_MUL_FLAGS_EN
        , input out_flags
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
`ifdef FP_MUL_FLAGS_EN
        , output out_flags
`endif
    );

endinterface

// File: rtl/fp_mul_round.sv
// fp_mul_round: combinational normalise + round-to-nearest-even for a
// (MAN_W+1)x(MAN_W+1) significand product.
//   prod    in  2*MAN_W+2  raw significand product, leading one in one of the top two bits
//   exp_in  in  EXP_W+2    signed biased exponent before normalisation
//   man     out MAN_W      rounded stored mantissa (hidden bit dropped)
//   exp_out out EXP_W+2    signed biased exponent after normalisation and rounding carry
//   inexact out 1          guard or sticky was set
module fp_mul_round #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic        [2*MAN_W+1:0] prod,
    input  logic signed [EXP_W+1:0]   exp_in,
    output logic        [MAN_W-1:0]   man,
    output logic signed [EXP_W+1:0]   exp_out,
    output logic                      inexact
);
    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned XW = EXP_W + 2;

    logic [PW-1:0]    norm;
    logic [MAN_W:0]   kept;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [MAN_W+1:0] rounded;

    always_comb begin
        // Left-align so the leading one always sits in the MSB.
        norm     = prod[PW-1] ? prod : (prod << 1);
        kept     = norm[PW-1:MAN_W+1];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = guard & (sticky | kept[0]);
        rounded  = {1'b0, kept} + (MAN_W+2)'(round_up);
        // A carry out of rounding leaves 1.000..0, so the stored bits are all zero.
        man      = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        exp_out  = exp_in + XW'(prod[PW-1]) + XW'(rounded[MAN_W+1]);
        inexact  = guard | sticky;
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined IEEE-754 multiplier, flush-to-zero, RNE.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears valids and output registers)
//   bus  - fp_mul_if.slave: in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_result,
//          plus out_flags when FP_MUL_FLAGS_EN is defined
// Stages: S1 unpack/classify/multiply, S2 normalise/round, S3 special cases and pack.
// Define FP_MUL_FLAGS_EN to build the exception-flag pipeline and out_flags.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic     clk,
    input logic     rst,
    fp_mul_if.slave bus
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned XW = EXP_W + 2;

    localparam logic signed [XW-1:0] Bias    = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [XW-1:0] ExpOvf  = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [XW-1:0] ExpZero = '0;
    localparam logic [MaxWidth-1:0]  NanFull = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]         NanVal  = NanFull[W-1:0];

    // Handshake
    logic stall;
    logic s1_valid_q, s2_valid_q, out_valid_q;
    logic [W-1:0] out_result_q;

    assign stall          = out_valid_q & ~bus.out_ready;
    // Reset forces readiness; anything offered during reset is dropped anyway.
    assign bus.in_ready   = rst | ~stall;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;

    // S1: unpack and multiply
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic [PW-1:0]    sig_a, sig_b;
    fp_class_e        cls_a, cls_b;

    assign exp_a = bus.in_a[W-2:MAN_W];
    assign exp_b = bus.in_b[W-2:MAN_W];
    assign man_a = bus.in_a[MAN_W-1:0];
    assign man_b = bus.in_b[MAN_W-1:0];
    assign sig_a = {{(MAN_W+1){1'b0}}, 1'b1, man_a};
    assign sig_b = {{(MAN_W+1){1'b0}}, 1'b1, man_b};
    assign cls_a = classify(&exp_a, ~|exp_a, ~|man_a, man_a[MAN_W-1]);
    assign cls_b = classify(&exp_b, ~|exp_b, ~|man_b, man_b[MAN_W-1]);

    logic                 s1_sign_q;
    fp_class_e            s1_cls_a_q, s1_cls_b_q;
    logic [PW-1:0]        s1_prod_q;
    logic signed [XW-1:0] s1_exp_q;

    // S2: normalise and round
    logic [MAN_W-1:0]     rnd_man;
    logic signed [XW-1:0] rnd_exp;
    logic                 rnd_inexact;

    fp_mul_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .prod    (s1_prod_q),
        .exp_in  (s1_exp_q),
        .man     (rnd_man),
        .exp_out (rnd_exp),
        .inexact (rnd_inexact)
    );

    logic                 s2_sign_q;
    fp_class_e            s2_cls_a_q, s2_cls_b_q;
    logic [MAN_W-1:0]     s2_man_q;
    logic signed [XW-1:0] s2_exp_q;
`ifdef FP_MUL_FLAGS_EN
    logic                 s2_inexact_q;
`else
    logic                 unused_rnd_inexact;
    assign unused_rnd_inexact = rnd_inexact;
`endif

    // Payload registers carry no reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_sign_q  <= bus.in_a[W-1] ^ bus.in_b[W-1];
            s1_cls_a_q <= cls_a;
            s1_cls_b_q <= cls_b;
            s1_prod_q  <= sig_a * sig_b;
            s1_exp_q   <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - Bias;
            s2_sign_q  <= s1_sign_q;
            s2_cls_a_q <= s1_cls_a_q;
            s2_cls_b_q <= s1_cls_b_q;
            s2_man_q   <= rnd_man;
            s2_exp_q   <= rnd_exp;
`ifdef FP_MUL_FLAGS_EN
            s2_inexact_q <= rnd_inexact;
`endif
        end
    end

    // S3: special-case priority and range check
    logic a_nan, b_nan, inf_zero, any_inf, any_zero, special;
    logic case_nan, case_inf, case_zero, case_ovf, case_unf;
    logic [W-1:0] result;

    assign a_nan     = (s2_cls_a_q == ClsQnan) | (s2_cls_a_q == ClsSnan);
    assign b_nan     = (s2_cls_b_q == ClsQnan) | (s2_cls_b_q == ClsSnan);
    assign any_inf   = (s2_cls_a_q == ClsInf) | (s2_cls_b_q == ClsInf);
    assign any_zero  = (s2_cls_a_q == ClsZero) | (s2_cls_b_q == ClsZero);
    assign inf_zero  = any_inf & any_zero;
    assign case_nan  = a_nan | b_nan | inf_zero;
    assign case_inf  = ~case_nan & any_inf;
    assign case_zero = ~case_nan & ~case_inf & any_zero;
    assign special   = case_nan | case_inf | case_zero;
    assign case_ovf  = ~special & (s2_exp_q >= ExpOvf);
    assign case_unf  = ~special & (s2_exp_q <= ExpZero);

    always_comb begin
        result = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_man_q};
        if (case_nan) begin
            result = NanVal;
        end else if (case_inf | case_ovf) begin
            result = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (case_zero | case_unf) begin
            result = {s2_sign_q, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (!stall) begin
            s1_valid_q  <= bus.in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_result_q <= result;
            end
        end
    end

`ifdef FP_MUL_FLAGS_EN
    logic      a_snan, b_snan;
    fp_flags_t flags, out_flags_q;

    assign a_snan = s2_cls_a_q == ClsSnan;
    assign b_snan = s2_cls_b_q == ClsSnan;

    always_comb begin
        flags           = '0;
        flags.invalid   = case_nan & (inf_zero | a_snan | b_snan);
        flags.overflow  = case_ovf;
        flags.underflow = case_unf;
        // Rounding inexact is meaningless once a special value overrides the product.
        flags.inexact   = case_ovf | case_unf | (~special & s2_inexact_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_flags_q <= '0;
        end else if (!stall && s2_valid_q) begin
            out_flags_q <= flags;
        end
    end

    assign bus.out_flags = out_flags_q;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: self-checking bench for fp_mul_pipe (EXP_W=8, MAN_W=23).
// Flag checks are compiled in only when FP_MUL_FLAGS_EN is defined.
module tb_fp_mul_pipe;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int NumRand = 300;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    fp_mul_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive on the falling edge, observe 1 ns later (transfers happen at the next rise).
    task automatic step(input logic rs, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic rdy);
        @(negedge clk);
        rst           = rs;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = rdy;
        #1;
    endtask

    // Exact product, then round by comparing the discarded remainder with one half.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        int ea, eb, e, k;
        longint unsigned ma, mb, p, q, rem, half;
        logic s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = 64'(a[22:0]);
        mb = 64'(b[22:0]);
        s  = a[31] ^ b[31];
        a_zero = ea == 0;
        b_zero = eb == 0;
        a_inf  = ea == 255 && ma == 0;
        b_inf  = eb == 255 && mb == 0;
        a_nan  = ea == 255 && ma != 0;
        b_nan  = eb == 255 && mb != 0;
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        f = 4'b0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            r    = 32'h7FC00000;
            f[3] = a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf);
        end else if (a_inf || b_inf) begin
            r = {s, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            r = {s, 31'h0};
        end else begin
            p = (ma | 64'h800000) * (mb | 64'h800000);
            e = ea + eb - 127;
            if (p >= (64'd1 << 47)) begin
                k = 24;
                e = e + 1;
            end else begin
                k = 23;
            end
            q    = p >> k;
            rem  = p & ((64'd1 << k) - 64'd1);
            half = 64'd1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0};
                f = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 4'b0011;
            end else begin
                r = {s, e[7:0], q[22:0]};
                f = {3'b000, rem != 0};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 11))
            0: x[30:0] = 31'h0;
            1: x[30:0] = {8'hFF, 23'h0};
            2: x[30:22] = 9'h1FF;
            3: begin x[30:22] = 9'h1FE; x[0] = 1'b1; end
            4: x[30:23] = 8'h00;
            5: x[30:23] = 8'($urandom_range(200, 254));
            6: x[30:23] = 8'($urandom_range(1, 40));
            default: x[30:23] = 8'($urandom_range(90, 165));
        endcase
        return x;
    endfunction

    function automatic logic [31:0] rand_norm();
        logic [31:0] x;
        x = $urandom;
        x[30:23] = 8'($urandom_range(100, 150));
        return x;
    endfunction

    task automatic test_reset();
        int seen;
        step(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 1'b1);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_result !== 32'h0) begin
            n_err++; $display("FAIL reset_out_result: got %h want 00000000", bus.out_result);
        end
`ifdef FP_MUL_FLAGS_EN
        n_cmp++;
        if (bus.out_flags !== 4'b0000) begin
            n_err++; $display("FAIL reset_out_flags: got %b want 0000", bus.out_flags);
        end
`endif
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            if (bus.out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL reset_ignored_input: got %0d outputs want 0", seen);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [10] = '{32'h3FC00000, 32'h3F800001, 32'hBF800000, 32'h7F800000,
                                 32'h7FC00000, 32'h80000000, 32'h7F7FFFFF, 32'h0D800000,
                                 32'h00000001, 32'h7F800001};
        logic [31:0] vb [10] = '{32'h40000000, 32'h3F800001, 32'h3F800000, 32'h00000000,
                                 32'h3F800000, 32'h40000000, 32'h40000000, 32'h0D800000,
                                 32'h3F800000, 32'h3F800000};
        logic [31:0] vr [10] = '{32'h40400000, 32'h3F800002, 32'hBF800000, 32'h7FC00000,
                                 32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000,
                                 32'h00000000, 32'h7FC00000};
        logic [3:0]  vf [10] = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000,
                                 4'b0000, 4'b0101, 4'b0011, 4'b0000, 4'b1000};
        int lat;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, va[i], vb[i], 1'b1);
            lat = 0;
            do begin
                step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
                lat++;
            end while (!bus.out_valid && lat < 8);
            n_cmp++;
            if (lat != 3) begin
                n_err++; $display("FAIL latency[%0d]: got %0d want 3", i, lat);
            end
            n_cmp++;
            if (bus.out_result !== vr[i]) begin
                n_err++;
                $display("FAIL directed[%0d] %h*%h: got %h want %h", i, va[i], vb[i],
                         bus.out_result, vr[i]);
            end
`ifdef FP_MUL_FLAGS_EN
            n_cmp++;
            if (bus.out_flags !== vf[i]) begin
                n_err++; $display("FAIL flags[%0d]: got %b want %b", i, bus.out_flags, vf[i]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa [6], ob [6], er [6];
        logic [3:0]  ef [6];
        logic [31:0] held;
        logic        rdy, v;
        int          sent, got;
        for (int i = 0; i < 6; i++) begin
            oa[i] = rand_norm();
            ob[i] = rand_norm();
            ref_mul(oa[i], ob[i], er[i], ef[i]);
        end
        sent = 0;
        got  = 0;
        held = 32'h0;
        for (int c = 0; c < 30; c++) begin
            rdy = !(c >= 3 && c <= 7);
            v   = sent < 6;
            step(1'b0, v, v ? oa[sent] : 32'h0, v ? ob[sent] : 32'h0, rdy);
            if (c == 3) begin
                held = bus.out_result;
                n_cmp++;
                if (bus.out_valid !== 1'b1) begin
                    n_err++; $display("FAIL b2b_first_valid: got %b want 1", bus.out_valid);
                end
            end
            if (c >= 3 && c <= 7) begin
                n_cmp++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++; $display("FAIL b2b_in_ready@%0d: got %b want 0", c, bus.in_ready);
                end
            end
            if (c >= 4 && c <= 7) begin
                n_cmp++;
                if (bus.out_result !== held) begin
                    n_err++;
                    $display("FAIL b2b_hold@%0d: got %h want %h", c, bus.out_result, held);
                end
            end
            if (v && bus.in_ready) sent++;
            if (bus.out_valid && rdy) begin
                n_cmp++;
                if (got >= 6) begin
                    n_err++; $display("FAIL b2b_extra: got %h want no output", bus.out_result);
                end else if (bus.out_result !== er[got]) begin
                    n_err++;
                    $display("FAIL b2b_result[%0d]: got %h want %h", got, bus.out_result, er[got]);
                end
                got++;
            end
        end
        n_cmp++;
        if (got != 6) begin
            n_err++; $display("FAIL b2b_count: got %0d want 6", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_r[$];
        logic [3:0]  exp_f[$];
        logic [31:0] a, b, r, prev_res, want_r;
        logic [3:0]  f, want_f;
        logic        v, rdy, prev_stall;
        int          sent, got, cyc;
        sent = 0;
        got = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_res = 32'h0;
        while ((sent < NumRand || got < sent) && cyc < 5000) begin
            v   = (sent < NumRand) && ($urandom_range(0, 3) != 0);
            rdy = $urandom_range(0, 3) != 0;
            a   = rand_op();
            b   = rand_op();
            step(1'b0, v, a, b, rdy);
            cyc++;
            n_cmp++;
            if (bus.in_ready !== !(bus.out_valid && !rdy)) begin
                n_err++;
                $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, bus.in_ready,
                         !(bus.out_valid && !rdy));
            end
            if (prev_stall) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_result !== prev_res) begin
                    n_err++;
                    $display("FAIL rnd_hold@%0d: got %b/%h want 1/%h", cyc, bus.out_valid,
                             bus.out_result, prev_res);
                end
            end
            if (v && bus.in_ready) begin
                ref_mul(a, b, r, f);
                exp_r.push_back(r);
                exp_f.push_back(f);
                sent++;
            end
            if (bus.out_valid && rdy) begin
                n_cmp++;
                if (exp_r.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious: got %h want no output", bus.out_result);
                end else begin
                    want_r = exp_r.pop_front();
                    want_f = exp_f.pop_front();
                    got++;
                    if (bus.out_result !== want_r) begin
                        n_err++;
                        $display("FAIL rnd_result[%0d]: got %h want %h", got, bus.out_result,
                                 want_r);
                    end
`ifdef FP_MUL_FLAGS_EN
                    n_cmp++;
                    if (bus.out_flags !== want_f) begin
                        n_err++;
                        $display("FAIL rnd_flags[%0d]: got %b want %b", got, bus.out_flags,
                                 want_f);
                    end
`endif
                end
            end
            prev_stall = bus.out_valid && !rdy;
            prev_res   = bus.out_result;
        end
        n_cmp++;
        if (got != NumRand) begin
            n_err++; $display("FAIL rnd_count: got %0d want %0d", got, NumRand);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] a, b, r;
        logic [3:0]  f;
        int seen, lat;
        step(1'b0, 1'b1, rand_norm(), rand_norm(), 1'b0);
        step(1'b0, 1'b1, rand_norm(), rand_norm(), 1'b0);
        step(1'b0, 1'b1, rand_norm(), rand_norm(), 1'b0);
        step(1'b1, 1'b1, rand_norm(), rand_norm(), 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL mid_full: got %b want 1", bus.out_valid);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_flush: got %b want 0", bus.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            if (bus.out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL mid_stale: got %0d outputs want 0", seen);
        end
        a = rand_norm();
        b = rand_norm();
        ref_mul(a, b, r, f);
        step(1'b0, 1'b1, a, b, 1'b1);
        lat = 0;
        do begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            lat++;
        end while (!bus.out_valid && lat < 8);
        n_cmp++;
        if (lat != 3) begin
            n_err++; $display("FAIL mid_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (bus.out_result !== r) begin
            n_err++; $display("FAIL mid_result: got %h want %h", bus.out_result, r);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'h0;
        bus.in_b      = 32'h0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
